psum_accum_16b: RTL
===================

// Module: psum_accum_16b
// PURPOSE
// Upstream neighbour of the 16b->8b round/saturate stage. Accumulates a stream of
// signed 16b partial products into a wide accumulator. At end of a dot-product it
// adds an optional bias, saturates to signed 16b and presents one result per vector
// on a valid/ready output. The rounding stage takes that output as its dat_i.
// PARAMETERS
// DAT_W   16  width of signed input partial products and of the bias
// ACC_W   24  width of the signed internal accumulator (must be >= DAT_W+1)
// OUT_W   16  width of the signed saturated output
// CNT_W   10  width of the beat counter; maximum vector length is 2^CNT_W-1 beats
// PORTS
// i_clk        in   1      clock; all logic is rising-edge
// i_rst        in   1      synchronous, active-high reset
// i_in_valid   in   1      input beat valid
// o_in_ready   out  1      input beat accepted when i_in_valid & o_in_ready
// i_in_first   in   1      beat is the first of a vector (clears the accumulator)
// i_in_last    in   1      beat is the last of a vector (triggers output)
// i_in_dat     in   DAT_W  signed partial product
// i_bias_en    in   1      add i_bias at the end of the vector (sampled on the last beat)
// i_bias       in   DAT_W  signed bias (sampled on the last beat)
// o_out_valid  out  1      result valid
// i_out_ready  in   1      downstream accepts result
// o_out_dat    out  OUT_W  saturated signed result
// o_out_sat    out  1      result was clipped (valid alongside o_out_dat)
// o_out_cnt    out  CNT_W  number of beats accumulated for this result
// o_busy       out  1      accumulation in progress (state ACC)
// BEHAVIOUR
// - Reset (i_rst=1 at a clock edge): state=IDLE, acc=0, beat counter=0, o_out_valid=0,
//   o_out_dat=0, o_out_sat=0, o_out_cnt=0, o_busy=0. Reset mid-vector discards all work.
// - o_in_ready = ~o_out_valid | i_out_ready. The block stalls the whole input while an
//   unaccepted result is held, so input data is never lost.
// - FSM states:
//   IDLE: an accepted beat with first=1 loads acc = sext(dat) and sets cnt=1, then goes to
//     ACC. If last=1 on the same beat, it finalizes instead and stays in IDLE. An accepted
//     beat with first=0 in IDLE is dropped: no state change, no output.
//   ACC: an accepted beat adds acc += sext(dat) and cnt += 1. A beat with last=1 finalizes
//     and returns to IDLE. A beat with first=1 restarts: acc = sext(dat), cnt = 1, and the
//     old partial sum is discarded. first & last together restart and finalize one beat.
// - Accumulator add is two's-complement at ACC_W with no internal saturation; wrap is the
//   caller's responsibility. The beat counter saturates at all-ones.
// - Finalize (one-cycle latency): at the edge that accepts the last beat,
//   sum = acc_next + (i_bias_en ? sext(i_bias) : 0), computed at ACC_W+1 bits.
//   o_out_dat is max(min(sum, 2^(OUT_W-1)-1), -2^(OUT_W-1)).
//   o_out_sat = 1 if clipped. o_out_cnt = cnt_next. o_out_valid = 1 from the next cycle.
// - o_out_valid falls at the edge where i_out_ready=1, unless a new finalize happens at
//   the same edge. In that case o_out_valid stays 1 and the output regs take the new result.
// - Output regs (dat, sat, cnt) hold their value while o_out_valid & ~i_out_ready.
// - o_busy = (state == ACC).
// TESTING
// 1. Beats 100, -30, 5 (first on beat 1, last on beat 3), bias off, ready=1
//    -> o_out_dat=75, o_out_sat=0, o_out_cnt=3, valid 1 cycle after the last beat.
// 2. Beats 0x7FFF x4, bias_en with bias=1 -> sum=131069 -> o_out_dat=0x7FFF, o_out_sat=1.
//    Beats 0x8000 x2 -> o_out_dat=0x8000, o_out_sat=1.
// 3. Single beat with first&last, dat=-7, bias=+3 -> o_out_dat=-4, o_out_cnt=1.
// 4. Hold i_out_ready=0 after a result -> o_in_ready=0, input stalls and output regs are
//    stable. Raise ready on the same cycle a new last beat is accepted -> back-to-back
//    results with no bubble and none lost.
// 5. Mid-vector first (10, 20, then first=1 with 5, last with 1) -> o_out_dat=6,
//    o_out_cnt=2. A beat with first=0 in IDLE -> no output.
// 6. Assert i_rst for one cycle after 2 beats of a vector -> all outputs 0, state IDLE.
//    The following vector 1, 2 (first, last) -> o_out_dat=3.

Source files
------------

// File: rtl/psum_accum_16b.sv
// psum_accum_16b: accumulates signed partial products per vector, adds optional bias,
// saturates to OUT_W and presents one result per vector on a valid/ready output.
module psum_accum_16b #(
    parameter int DAT_W = 16,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_in_first,
    input  logic             i_in_last,
    input  logic [DAT_W-1:0] i_in_dat,
    input  logic             i_bias_en,
    input  logic [DAT_W-1:0] i_bias,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_out_dat,
    output logic             o_out_sat,
    output logic [CNT_W-1:0] o_out_cnt,
    output logic             o_busy
);
    typedef enum logic {IDLE, ACC} state_t;

    localparam logic signed [ACC_W:0] SMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SMIN = ~SMAX;

    state_t                  state, state_n;
    logic signed [ACC_W-1:0] acc, acc_next;
    logic        [CNT_W-1:0] cnt, cnt_next;
    logic signed [ACC_W:0]   sum;
    logic                    fire, take, fin, hi, lo;

    assign o_in_ready = ~o_out_valid | i_out_ready;
    assign o_busy     = (state == ACC);
    assign fire       = i_in_valid & o_in_ready;
    // A beat without first while idle belongs to no vector and is dropped.
    assign take       = fire & (i_in_first | (state == ACC));
    assign fin        = take & i_in_last;

    always_comb begin
        acc_next = i_in_first ? {{(ACC_W-DAT_W){i_in_dat[DAT_W-1]}}, i_in_dat}
                              : acc + {{(ACC_W-DAT_W){i_in_dat[DAT_W-1]}}, i_in_dat};
        cnt_next = i_in_first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
        sum      = {acc_next[ACC_W-1], acc_next}
                 + (i_bias_en ? {{(ACC_W+1-DAT_W){i_bias[DAT_W-1]}}, i_bias} : '0);
        hi       = sum > SMAX;
        lo       = sum < SMIN;
        state_n  = take ? (i_in_last ? IDLE : ACC) : state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                acc <= acc_next;
                cnt <= cnt_next;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_out_valid <= 1'b0;
            o_out_dat   <= '0;
            o_out_sat   <= 1'b0;
            o_out_cnt   <= '0;
        end else if (fin) begin
            o_out_valid <= 1'b1;
            o_out_dat   <= hi ? SMAX[OUT_W-1:0] : lo ? SMIN[OUT_W-1:0] : sum[OUT_W-1:0];
            o_out_sat   <= hi | lo;
            o_out_cnt   <= cnt_next;
        end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
        end
    end
endmodule
